// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for serial_subtractor.
// The master drives the request and operands; the slave (the subtractor) returns status and results.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one full-subtractor cell plus a borrow flop.
// Optional macro SERIAL_SUBTRACTOR_SIGNED_EN builds the signed-overflow flag; otherwise ovf is tied to 0.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-2:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               br_q, br_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               done_q, done_d;

    logic               bit_x;
    logic               bit_y;
    logic               bit_d;
    logic               br_next;
    logic [WIDTH-1:0]   shifted;

    // Full-subtractor cell on the current LSBs; the new bit enters the result from the MSB side.
    assign bit_x   = sa_q[0];
    assign bit_y   = sb_q[0];
    assign bit_d   = bit_x ^ bit_y ^ br_q;
    assign br_next = (~bit_x & bit_y) | (~bit_x & br_q) | (bit_y & br_q);
    assign shifted = {bit_d, res_q};

`ifdef SERIAL_SUBTRACTOR_SIGNED_EN
    logic sign_a_q, sign_a_d;
    logic sign_b_q, sign_b_d;
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        done_d  = 1'b0;
`ifdef SERIAL_SUBTRACTOR_SIGNED_EN
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SERIAL_SUBTRACTOR_SIGNED_EN
                    sign_a_d = bus.a[WIDTH-1];
                    sign_b_d = bus.b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                res_d = shifted[WIDTH-1:1];
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                br_d  = br_next;
                // Final bit: publish the full result, the sign bit is the one just computed.
                if (cnt_q == LAST_CNT) begin
                    diff_d  = shifted;
                    bout_d  = br_next;
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef SERIAL_SUBTRACTOR_SIGNED_EN
                    ovf_d = (sign_a_q != sign_b_q) && (bit_d != sign_a_q);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
        end
    end

`ifdef SERIAL_SUBTRACTOR_SIGNED_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ovf only reflects signed overflow when the feature is built in
    function automatic logic expOvf(input logic signed_ovf);
`ifdef SERIAL_SUBTRACTOR_SIGNED_EN
        return signed_ovf;
`else
        return 1'b0 & signed_ovf;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse is compared against the oldest outstanding expectation
    always @(negedge clk) begin
        if (bus.done) begin
            checkOutput("busy_with_done", {31'b0, bus.busy}, 32'd0);
            checkOutput("done_one_cycle", {31'b0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("diff", {24'b0, bus.diff}, {24'b0, mon_e.diff});
                checkOutput("bout", {31'b0, bus.bout}, {31'b0, mon_e.bout});
                checkOutput("ovf", {31'b0, bus.ovf}, {31'b0, mon_e.ovf});
            end
        end
        prev_done = bus.done;
    end

    task automatic waitDone(output int lat);
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = i - 1;
                break;
            end
        end
        if (lat < 0) checkOutput("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic pushExp(input logic [7:0] d, input logic bo, input logic ov_signed);
        exp_t e;
        e.diff = d;
        e.bout = bo;
        e.ovf  = expOvf(ov_signed);
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] d, input logic bo, input logic ov_signed);
        int lat;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        pushExp(d, bo, ov_signed);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        waitDone(lat);
        checkOutput("latency", lat, WIDTH);
    endtask

    logic [7:0] op_a [3];
    logic [7:0] op_b [3];
    logic [7:0] op_d [3];
    logic       op_bo [3];
    logic       op_ov [3];
    int         done_cyc [3];

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin
        int lat;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("rst_done", {31'b0, bus.done}, 32'd0);
        checkOutput("rst_diff", {24'b0, bus.diff}, 32'd0);
        checkOutput("rst_bout", {31'b0, bus.bout}, 32'd0);
        checkOutput("rst_ovf", {31'b0, bus.ovf}, 32'd0);
        rst_n = 1'b1;

        $display("[TB] basic vectors");
        applyStimulus(8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
        applyStimulus(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        applyStimulus(8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0);
        applyStimulus(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        applyStimulus(8'h01, 8'h80, 8'h81, 1'b1, 1'b1);

        $display("[TB] start during RUN is ignored");
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a = 8'h3C;
        bus.b = 8'h0F;
        pushExp(8'h2D, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a = 8'hFF;
        bus.b = 8'h00;
        @(negedge clk);
        checkOutput("busy_during_run", {31'b0, bus.busy}, 32'd1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        waitDone(lat);
        checkOutput("latency_ignored", lat, 5);
        repeat (12) @(negedge clk);
        checkOutput("busy_not_queued", {31'b0, bus.busy}, 32'd0);

        $display("[TB] reset during RUN");
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a = 8'h10;
        bus.b = 8'h20;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("abort_done", {31'b0, bus.done}, 32'd0);
        checkOutput("abort_diff", {24'b0, bus.diff}, 32'd0);
        checkOutput("abort_bout", {31'b0, bus.bout}, 32'd0);
        checkOutput("abort_ovf", {31'b0, bus.ovf}, 32'd0);
        repeat (12) @(negedge clk);
        applyStimulus(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        $display("[TB] back-to-back with start held high");
        op_a = '{8'h01, 8'hC8, 8'h7F};
        op_b = '{8'h02, 8'h64, 8'h80};
        op_d = '{8'hFF, 8'h64, 8'hFF};
        op_bo = '{1'b1, 1'b0, 1'b1};
        op_ov = '{1'b0, 1'b1, 1'b1};
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a = op_a[0];
        bus.b = op_b[0];
        pushExp(op_d[0], op_bo[0], op_ov[0]);
        for (int k = 0; k < 3; k++) begin
            waitDone(lat);
            done_cyc[k] = cyc;
            if (k < 2) begin
                bus.a = op_a[k+1];
                bus.b = op_b[k+1];
                pushExp(op_d[k+1], op_bo[k+1], op_ov[k+1]);
            end else begin
                bus.start = 1'b0;
            end
        end
        checkOutput("period_1", done_cyc[1] - done_cyc[0], 9);
        checkOutput("period_2", done_cyc[2] - done_cyc[1], 9);

        repeat (12) @(negedge clk);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
